id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register plus EX-side operand forwarding; feeds the ALU directly (A, B, AluCtrl, shamt).
//  Captures decoded operands/control each cycle, resolves RAW hazards from EX/MEM and MEM/WB, detects
//  load-use hazards, honours stall/flush, and counts inserted bubbles for performance monitoring.
// PARAMETERS
//  CNT_W  16  width of saturating bubble counter o_data_BubbleCnt
// PORTS
//  i_clk              in   1      clock, all state on rising edge
//  i_rst_n            in   1      synchronous reset, active-low
//  i_con_Stall        in   1      hold all state (downstream memory wait)
//  i_con_Flush        in   1      replace incoming instruction with bubble (branch/jump redirect)
//  i_con_Valid        in   1      ID holds a real instruction
//  i_data_Rs          in   32     rs read data; for jal ID drives PC here with i_data_RsAddr=0
//  i_data_Rt          in   32     rt read data
//  i_data_Imm         in   32     extended immediate (lui uses Imm[15:0])
//  i_data_RsAddr      in   5      rs index
//  i_data_RtAddr      in   5      rt index
//  i_data_DstAddr     in   5      final destination reg (rd/rt/31 already selected by ID)
//  i_data_shamt       in   5      shift amount
//  i_con_AluCtrl      in   4      ALU op code
//  i_con_AluSrcB      in   1      1: B=Imm, 0: B=forwarded rt
//  i_con_RegWrite     in   1      instruction writes DstAddr
//  i_con_MemOp        in   2      00 none, 01 load, 10 store, 11 illegal (treated as 00)
//  i_data_ExMemRes    in   32     EX/MEM result; i_data_ExMemDst=0 means no write
//  i_data_ExMemDst    in   5      EX/MEM destination
//  i_data_MemWbRes    in   32     MEM/WB result; i_data_MemWbDst=0 means no write
//  i_data_MemWbDst    in   5      MEM/WB destination
//  o_data_A           out  32     ALU operand A (forwarded rs)
//  o_data_B           out  32     ALU operand B
//  o_data_StoreData   out  32     forwarded rt for stores
//  o_con_AluCtrl      out  4      registered ALU op
//  o_data_shamt       out  5      registered shamt
//  o_data_DstAddr     out  5      registered destination, 0 when bubble
//  o_con_RegWrite     out  1      registered, 0 when bubble
//  o_con_MemOp        out  2      registered, 00 when bubble
//  o_con_Valid        out  1      EX holds a real instruction
//  o_con_LoadUse      out  1      load-use hazard; IF/ID must hold
//  o_data_BubbleCnt   out  CNT_W  saturating count of bubbles inserted by flush/load-use
// BEHAVIOUR
//  - Reset (i_rst_n=0 at edge): all registers 0, o_con_Valid=0, BubbleCnt=0; priority reset>stall>bubble>load.
//  - Stall=1: every register holds, counter holds; Flush and LoadUse ignored that cycle.
//  - Bubble (Flush=1 or o_con_LoadUse=1, no stall): Valid/RegWrite/MemOp/DstAddr<=0, data regs don't-care
//    (implement as 0); BubbleCnt+=1, saturating at 2^CNT_W-1. Flush and LoadUse together count once.
//  - Otherwise load all inputs; MemOp=11 registered as 00; Valid<=i_con_Valid.
//  - Latency: 1 cycle ID->EX. o_data_A/B/StoreData combinational from registered state + forward inputs.
//  - Forwarding (per rs/rt): addr!=0 & addr==ExMemDst -> ExMemRes; else addr!=0 & addr==MemWbDst -> MemWbRes;
//    else registered read data. EX/MEM wins over MEM/WB. Register 0 never forwarded.
//  - o_data_B = AluSrcB ? reg Imm : forwarded rt; o_data_StoreData always forwarded rt.
//  - o_con_LoadUse = o_con_Valid & o_con_MemOp==01 & o_data_DstAddr!=0 &
//    (DstAddr==i_data_RsAddr | DstAddr==i_data_RtAddr) & i_con_Valid; combinational, not gated by stall.
//  - Reset mid-stall or mid-hazard: next cycle is empty pipe, LoadUse=0.
// TESTING
//  - add: Rs=5,Rt=7,AluSrcB=0, no fwd -> next cycle A=5,B=7,Valid=1; AluSrcB=1,Imm=0x10 -> B=0x10.
//  - RsAddr=3, ExMemDst=3/Res=0xAA, MemWbDst=3/Res=0xBB -> A=0xAA; ExMemDst=0 -> A=0xBB; RsAddr=0 -> A=Rs.
//  - EX holds lw DstAddr=8; ID RtAddr=8,Valid=1 -> LoadUse=1, next cycle Valid=0,RegWrite=0, BubbleCnt=1.
//  - Stall=1 with Flush=1 for 3 cycles -> outputs and BubbleCnt frozen; Stall drop + Flush=1 -> one bubble.
//  - CNT_W=2, 5 consecutive flushes -> BubbleCnt sequence 1,2,3,3,3.
//  - Mid-operation i_rst_n=0 one cycle during stall -> all outputs 0, Valid=0, BubbleCnt=0 next cycle.

Source files
------------

// File: rtl/id_ex_stage_if.sv
// Bundle of ID-side inputs, forwarding sources and EX-side outputs around the ID/EX register.
// The master side drives the decoded instruction; the slave side is the pipeline stage itself.
interface id_ex_stage_if #(
  parameter int CNT_W = 16
);
  logic             i_con_Stall;
  logic             i_con_Flush;
  logic             i_con_Valid;
  logic [31:0]      i_data_Rs;
  logic [31:0]      i_data_Rt;
  logic [31:0]      i_data_Imm;
  logic [4:0]       i_data_RsAddr;
  logic [4:0]       i_data_RtAddr;
  logic [4:0]       i_data_DstAddr;
  logic [4:0]       i_data_shamt;
  logic [3:0]       i_con_AluCtrl;
  logic             i_con_AluSrcB;
  logic             i_con_RegWrite;
  logic [1:0]       i_con_MemOp;
  logic [31:0]      i_data_ExMemRes;
  logic [4:0]       i_data_ExMemDst;
  logic [31:0]      i_data_MemWbRes;
  logic [4:0]       i_data_MemWbDst;

  logic [31:0]      o_data_A;
  logic [31:0]      o_data_B;
  logic [31:0]      o_data_StoreData;
  logic [3:0]       o_con_AluCtrl;
  logic [4:0]       o_data_shamt;
  logic [4:0]       o_data_DstAddr;
  logic             o_con_RegWrite;
  logic [1:0]       o_con_MemOp;
  logic             o_con_Valid;
  logic             o_con_LoadUse;
  logic [CNT_W-1:0] o_data_BubbleCnt;

  modport master (
    output i_con_Stall, i_con_Flush, i_con_Valid, i_data_Rs, i_data_Rt, i_data_Imm,
           i_data_RsAddr, i_data_RtAddr, i_data_DstAddr, i_data_shamt, i_con_AluCtrl,
           i_con_AluSrcB, i_con_RegWrite, i_con_MemOp, i_data_ExMemRes, i_data_ExMemDst,
           i_data_MemWbRes, i_data_MemWbDst,
    input  o_data_A, o_data_B, o_data_StoreData, o_con_AluCtrl, o_data_shamt, o_data_DstAddr,
           o_con_RegWrite, o_con_MemOp, o_con_Valid, o_con_LoadUse, o_data_BubbleCnt
  );

  modport slave (
    input  i_con_Stall, i_con_Flush, i_con_Valid, i_data_Rs, i_data_Rt, i_data_Imm,
           i_data_RsAddr, i_data_RtAddr, i_data_DstAddr, i_data_shamt, i_con_AluCtrl,
           i_con_AluSrcB, i_con_RegWrite, i_con_MemOp, i_data_ExMemRes, i_data_ExMemDst,
           i_data_MemWbRes, i_data_MemWbDst,
    output o_data_A, o_data_B, o_data_StoreData, o_con_AluCtrl, o_data_shamt, o_data_DstAddr,
           o_con_RegWrite, o_con_MemOp, o_con_Valid, o_con_LoadUse, o_data_BubbleCnt
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-side operand forwarding, load-use detection,
// stall/flush handling and a saturating count of inserted bubbles.
module id_ex_stage #(
  parameter int CNT_W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  id_ex_stage_if.slave bus
);

  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic [1:0]  mem_op;
    logic [4:0]  dst;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [4:0]  shamt;
    logic [3:0]  alu_ctrl;
    logic        alu_src_b;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] imm;
  } ex_t;

  ex_t              stage_q, stage_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load_use;
  logic             bubble;
  logic [31:0]      rs_fwd;
  logic [31:0]      rt_fwd;

  // EX/MEM is the younger producer, so it wins over MEM/WB; r0 is hardwired zero.
  function automatic logic [31:0] fwd(input logic [4:0]  addr,
                                      input logic [31:0] reg_val,
                                      input logic [4:0]  exmem_dst,
                                      input logic [31:0] exmem_res,
                                      input logic [4:0]  memwb_dst,
                                      input logic [31:0] memwb_res);
    if (addr != 5'd0 && addr == exmem_dst) begin
      return exmem_res;
    end else if (addr != 5'd0 && addr == memwb_dst) begin
      return memwb_res;
    end
    return reg_val;
  endfunction

  assign load_use = stage_q.valid && (stage_q.mem_op == 2'b01) && (stage_q.dst != 5'd0) &&
                    ((stage_q.dst == bus.i_data_RsAddr) || (stage_q.dst == bus.i_data_RtAddr)) &&
                    bus.i_con_Valid;

  assign bubble = bus.i_con_Flush || load_use;

  always_comb begin
    stage_d = stage_q;
    cnt_d   = cnt_q;
    if (!bus.i_con_Stall) begin
      if (bubble) begin
        stage_d = '0;
        if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        stage_d.valid     = bus.i_con_Valid;
        stage_d.reg_write = bus.i_con_RegWrite;
        stage_d.mem_op    = (bus.i_con_MemOp == 2'b11) ? 2'b00 : bus.i_con_MemOp;
        stage_d.dst       = bus.i_data_DstAddr;
        stage_d.rs_addr   = bus.i_data_RsAddr;
        stage_d.rt_addr   = bus.i_data_RtAddr;
        stage_d.shamt     = bus.i_data_shamt;
        stage_d.alu_ctrl  = bus.i_con_AluCtrl;
        stage_d.alu_src_b = bus.i_con_AluSrcB;
        stage_d.rs        = bus.i_data_Rs;
        stage_d.rt        = bus.i_data_Rt;
        stage_d.imm       = bus.i_data_Imm;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      stage_q <= '0;
      cnt_q   <= '0;
    end else begin
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rs_fwd = fwd(stage_q.rs_addr, stage_q.rs, bus.i_data_ExMemDst, bus.i_data_ExMemRes,
                      bus.i_data_MemWbDst, bus.i_data_MemWbRes);
  assign rt_fwd = fwd(stage_q.rt_addr, stage_q.rt, bus.i_data_ExMemDst, bus.i_data_ExMemRes,
                      bus.i_data_MemWbDst, bus.i_data_MemWbRes);

  assign bus.o_data_A         = rs_fwd;
  assign bus.o_data_B         = stage_q.alu_src_b ? stage_q.imm : rt_fwd;
  assign bus.o_data_StoreData = rt_fwd;
  assign bus.o_con_AluCtrl    = stage_q.alu_ctrl;
  assign bus.o_data_shamt     = stage_q.shamt;
  assign bus.o_data_DstAddr   = stage_q.dst;
  assign bus.o_con_RegWrite   = stage_q.reg_write;
  assign bus.o_con_MemOp      = stage_q.mem_op;
  assign bus.o_con_Valid      = stage_q.valid;
  assign bus.o_con_LoadUse    = load_use;
  assign bus.o_data_BubbleCnt = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed scenarios with literal expectations, then randomized traffic checked every cycle
// against an instruction-level model of the EX stage contents.
module tb_id_ex_stage;

  logic clk;
  logic rst_n;

  id_ex_stage_if #(.CNT_W(16)) bus ();
  id_ex_stage_if #(.CNT_W(2))  bus2 ();

  id_ex_stage #(.CNT_W(16)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus.slave));
  id_ex_stage #(.CNT_W(2))  dut2 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus2.slave));

  // The narrow-counter instance sees exactly the same stimulus.
  assign bus2.i_con_Stall     = bus.i_con_Stall;
  assign bus2.i_con_Flush     = bus.i_con_Flush;
  assign bus2.i_con_Valid     = bus.i_con_Valid;
  assign bus2.i_data_Rs       = bus.i_data_Rs;
  assign bus2.i_data_Rt       = bus.i_data_Rt;
  assign bus2.i_data_Imm      = bus.i_data_Imm;
  assign bus2.i_data_RsAddr   = bus.i_data_RsAddr;
  assign bus2.i_data_RtAddr   = bus.i_data_RtAddr;
  assign bus2.i_data_DstAddr  = bus.i_data_DstAddr;
  assign bus2.i_data_shamt    = bus.i_data_shamt;
  assign bus2.i_con_AluCtrl   = bus.i_con_AluCtrl;
  assign bus2.i_con_AluSrcB   = bus.i_con_AluSrcB;
  assign bus2.i_con_RegWrite  = bus.i_con_RegWrite;
  assign bus2.i_con_MemOp     = bus.i_con_MemOp;
  assign bus2.i_data_ExMemRes = bus.i_data_ExMemRes;
  assign bus2.i_data_ExMemDst = bus.i_data_ExMemDst;
  assign bus2.i_data_MemWbRes = bus.i_data_MemWbRes;
  assign bus2.i_data_MemWbDst = bus.i_data_MemWbDst;

  int n_vec  = 0;
  int n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the instruction currently held in EX, as the ID stage described it.
  bit          model_ok = 1'b0;
  bit          m_valid, m_regwrite, m_srcb;
  int          m_memop, m_dst, m_rsaddr, m_rtaddr, m_shamt, m_alu;
  logic [31:0] m_rs, m_rt, m_imm;
  int          m_bubbles;

  function automatic logic [31:0] operand(input int addr, input logic [31:0] own);
    if (addr == 0) return own;
    if (addr == int'(bus.i_data_ExMemDst)) return bus.i_data_ExMemRes;
    if (addr == int'(bus.i_data_MemWbDst)) return bus.i_data_MemWbRes;
    return own;
  endfunction

  function automatic bit exp_load_use();
    return m_valid && m_memop == 1 && m_dst != 0 && bus.i_con_Valid &&
           (m_dst == int'(bus.i_data_RsAddr) || m_dst == int'(bus.i_data_RtAddr));
  endfunction

  task automatic model_clear();
    m_valid = 0; m_regwrite = 0; m_srcb = 0;
    m_memop = 0; m_dst = 0; m_rsaddr = 0; m_rtaddr = 0; m_shamt = 0; m_alu = 0;
    m_rs = '0; m_rt = '0; m_imm = '0;
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      model_clear();
      m_bubbles = 0;
      model_ok  = 1'b1;
    end else if (bus.i_con_Stall) begin
      // EX frozen
    end else if (bus.i_con_Flush || exp_load_use()) begin
      model_clear();
      m_bubbles++;
    end else begin
      m_valid    = bus.i_con_Valid;
      m_regwrite = bus.i_con_RegWrite;
      m_srcb     = bus.i_con_AluSrcB;
      m_memop    = (bus.i_con_MemOp == 2'b11) ? 0 : int'(bus.i_con_MemOp);
      m_dst      = int'(bus.i_data_DstAddr);
      m_rsaddr   = int'(bus.i_data_RsAddr);
      m_rtaddr   = int'(bus.i_data_RtAddr);
      m_shamt    = int'(bus.i_data_shamt);
      m_alu      = int'(bus.i_con_AluCtrl);
      m_rs       = bus.i_data_Rs;
      m_rt       = bus.i_data_Rt;
      m_imm      = bus.i_data_Imm;
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      logic [31:0] a_exp, st_exp;
      a_exp  = operand(m_rsaddr, m_rs);
      st_exp = operand(m_rtaddr, m_rt);
      check("A",         bus.o_data_A, a_exp);
      check("B",         bus.o_data_B, m_srcb ? m_imm : st_exp);
      check("StoreData", bus.o_data_StoreData, st_exp);
      check("AluCtrl",   32'(bus.o_con_AluCtrl), 32'(m_alu));
      check("shamt",     32'(bus.o_data_shamt), 32'(m_shamt));
      check("DstAddr",   32'(bus.o_data_DstAddr), 32'(m_dst));
      check("RegWrite",  32'(bus.o_con_RegWrite), 32'(m_regwrite));
      check("MemOp",     32'(bus.o_con_MemOp), 32'(m_memop));
      check("Valid",     32'(bus.o_con_Valid), 32'(m_valid));
      check("LoadUse",   32'(bus.o_con_LoadUse), 32'(exp_load_use()));
      check("BubbleCnt16", 32'(bus.o_data_BubbleCnt), 32'((m_bubbles > 65535) ? 65535 : m_bubbles));
      check("BubbleCnt2",  32'(bus2.o_data_BubbleCnt), 32'((m_bubbles > 3) ? 3 : m_bubbles));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.i_con_Stall = 0; bus.i_con_Flush = 0; bus.i_con_Valid = 0;
    bus.i_data_Rs = '0; bus.i_data_Rt = '0; bus.i_data_Imm = '0;
    bus.i_data_RsAddr = '0; bus.i_data_RtAddr = '0; bus.i_data_DstAddr = '0;
    bus.i_data_shamt = '0; bus.i_con_AluCtrl = '0; bus.i_con_AluSrcB = 0;
    bus.i_con_RegWrite = 0; bus.i_con_MemOp = '0;
    bus.i_data_ExMemRes = '0; bus.i_data_ExMemDst = '0;
    bus.i_data_MemWbRes = '0; bus.i_data_MemWbDst = '0;
  endtask

  task automatic randomize_inputs();
    rst_n = ($urandom_range(0, 49) != 0);
    bus.i_con_Stall     = ($urandom_range(0, 5) == 0);
    bus.i_con_Flush     = ($urandom_range(0, 7) == 0);
    bus.i_con_Valid     = ($urandom_range(0, 9) != 0);
    bus.i_data_Rs       = $urandom;
    bus.i_data_Rt       = $urandom;
    bus.i_data_Imm      = $urandom;
    bus.i_data_RsAddr   = 5'($urandom_range(0, 4));
    bus.i_data_RtAddr   = 5'($urandom_range(0, 4));
    bus.i_data_DstAddr  = 5'($urandom_range(0, 4));
    bus.i_data_shamt    = 5'($urandom);
    bus.i_con_AluCtrl   = 4'($urandom);
    bus.i_con_AluSrcB   = 1'($urandom);
    bus.i_con_RegWrite  = 1'($urandom);
    bus.i_con_MemOp     = 2'($urandom);
    bus.i_data_ExMemRes = $urandom;
    bus.i_data_ExMemDst = 5'($urandom_range(0, 4));
    bus.i_data_MemWbRes = $urandom;
    bus.i_data_MemWbDst = 5'($urandom_range(0, 4));
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    tick();
    check("rst_Valid", 32'(bus.o_con_Valid), 32'd0);
    check("rst_Bubble", 32'(bus.o_data_BubbleCnt), 32'd0);
    check("rst_Dst", 32'(bus.o_data_DstAddr), 32'd0);
    rst_n = 1'b1;

    // add r4 = r1 + r2
    bus.i_con_Valid = 1; bus.i_data_Rs = 32'd5; bus.i_data_Rt = 32'd7;
    bus.i_data_RsAddr = 5'd1; bus.i_data_RtAddr = 5'd2; bus.i_data_DstAddr = 5'd4;
    bus.i_con_RegWrite = 1; bus.i_con_AluCtrl = 4'd2;
    tick(); idle(); #1;
    check("add_A", bus.o_data_A, 32'd5);
    check("add_B", bus.o_data_B, 32'd7);
    check("add_Valid", 32'(bus.o_con_Valid), 32'd1);

    bus.i_con_Valid = 1; bus.i_data_Rs = 32'd5; bus.i_data_Rt = 32'd7;
    bus.i_con_AluSrcB = 1; bus.i_data_Imm = 32'h10;
    tick(); idle(); #1;
    check("imm_B", bus.o_data_B, 32'h10);
    check("imm_Store", bus.o_data_StoreData, 32'd7);

    bus.i_con_Valid = 1; bus.i_data_RsAddr = 5'd3; bus.i_data_Rs = 32'h11;
    tick(); idle();
    bus.i_data_ExMemDst = 5'd3; bus.i_data_ExMemRes = 32'hAA;
    bus.i_data_MemWbDst = 5'd3; bus.i_data_MemWbRes = 32'hBB;
    #1 check("fwd_exmem", bus.o_data_A, 32'hAA);
    bus.i_data_ExMemDst = 5'd0;
    #1 check("fwd_memwb", bus.o_data_A, 32'hBB);
    idle();

    bus.i_con_Valid = 1; bus.i_data_RsAddr = 5'd0; bus.i_data_Rs = 32'h22;
    tick(); idle();
    bus.i_data_ExMemRes = 32'hAA; bus.i_data_MemWbRes = 32'hBB;
    #1 check("fwd_r0", bus.o_data_A, 32'h22);
    idle();

    // lw r8 followed by a consumer of r8
    bus.i_con_Valid = 1; bus.i_con_MemOp = 2'b01; bus.i_data_DstAddr = 5'd8; bus.i_con_RegWrite = 1;
    tick(); idle();
    bus.i_con_Valid = 1; bus.i_data_RtAddr = 5'd8;
    #1 check("lu_flag", 32'(bus.o_con_LoadUse), 32'd1);
    tick();
    check("lu_Valid", 32'(bus.o_con_Valid), 32'd0);
    check("lu_RegWrite", 32'(bus.o_con_RegWrite), 32'd0);
    check("lu_Bubble", 32'(bus.o_data_BubbleCnt), 32'd1);
    idle();

    bus.i_con_Valid = 1; bus.i_data_DstAddr = 5'd9; bus.i_con_RegWrite = 1;
    tick(); idle();
    bus.i_con_Stall = 1; bus.i_con_Flush = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_Valid", 32'(bus.o_con_Valid), 32'd1);
      check("stall_Dst", 32'(bus.o_data_DstAddr), 32'd9);
      check("stall_Bubble", 32'(bus.o_data_BubbleCnt), 32'd1);
    end
    bus.i_con_Stall = 0;
    tick();
    check("unstall_Valid", 32'(bus.o_con_Valid), 32'd0);
    check("unstall_Bubble", 32'(bus.o_data_BubbleCnt), 32'd2);
    idle();

    bus.i_con_Valid = 1; bus.i_data_DstAddr = 5'd9; bus.i_data_Rs = 32'h33;
    tick(); idle();
    bus.i_con_Stall = 1; rst_n = 1'b0;
    tick();
    check("rststall_Valid", 32'(bus.o_con_Valid), 32'd0);
    check("rststall_Bubble", 32'(bus.o_data_BubbleCnt), 32'd0);
    check("rststall_A", bus.o_data_A, 32'd0);
    rst_n = 1'b1; idle();

    bus.i_con_Flush = 1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("sat_cnt2", 32'(bus2.o_data_BubbleCnt), (i < 3) ? i : 3);
      check("sat_cnt16", 32'(bus.o_data_BubbleCnt), i);
    end
    idle();

    for (int i = 0; i < 3000; i++) begin
      tick();
      randomize_inputs();
    end
    tick();
    idle();
    rst_n = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
